// File: rtl/zap_shifter_divide_if.sv
// Handshake/bus bundle between the ALU sequencer and the iterative divider.
interface zap_shifter_divide_if #(
   parameter int WIDTH = 32
);
   logic             i_clear_from_writeback;
   logic             i_data_stall;
   logic             i_clear_from_alu;
   logic             i_start;
   logic             i_signed;
   logic             i_rem_sel;
   logic [WIDTH-1:0] i_rn;
   logic [WIDTH-1:0] i_rs;
   logic [WIDTH-1:0] o_rd;
   logic             o_busy;
   logic             o_done;
   logic             o_div_by_zero;

   // Sequencer side: issues operations, consumes results.
   modport master (
      output i_clear_from_writeback, i_data_stall, i_clear_from_alu,
             i_start, i_signed, i_rem_sel, i_rn, i_rs,
      input  o_rd, o_busy, o_done, o_div_by_zero
   );

   // Divider side.
   modport slave (
      input  i_clear_from_writeback, i_data_stall, i_clear_from_alu,
             i_start, i_signed, i_rem_sel, i_rn, i_rs,
      output o_rd, o_busy, o_done, o_div_by_zero
   );
endinterface

// File: rtl/zap_shifter_divide.sv
// Iterative radix-2 restoring 32/32 divider, one quotient bit per clock.
// Operands are converted to magnitudes up front; signs are reapplied in FIX.
module zap_shifter_divide #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   zap_shifter_divide_if.slave   div_if
);

   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   rem_q, rem_d;       // partial remainder
   logic [WIDTH-1:0]   quo_q, quo_d;       // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0]   div_q, div_d;       // divisor magnitude
   logic [WIDTH-1:0]   res_q, res_d;       // final signed result
   logic               qneg_q, qneg_d;
   logic               rneg_q, rneg_d;
   logic               rsel_q, rsel_d;
   logic               dbz_q, dbz_d;

   logic               busy, done, start_acc;
   logic               upd;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     trial;
   logic [WIDTH-1:0]   q_fix, r_fix;

   // Magnitude; in signed mode 0x80000000 negates to itself, which is
   // exactly the unsigned magnitude we want.
   function automatic logic [WIDTH-1:0] mag(input logic sgn, input logic [WIDTH-1:0] x);
      return (sgn && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
   endfunction

   // Datapath advances only when no flush or stall is pending.
   assign upd = ~div_if.i_clear_from_writeback & ~div_if.i_data_stall &
                ~div_if.i_clear_from_alu;

   // State register: writeback flush beats stall, stall beats ALU flush.
   always_ff @(posedge i_clk) begin
      if (i_reset)                          state_q <= IDLE;
      else if (div_if.i_clear_from_writeback) state_q <= IDLE;
      else if (div_if.i_data_stall)         state_q <= state_q;
      else if (div_if.i_clear_from_alu)     state_q <= IDLE;
      else                                  state_q <= state_d;
   end

   // Next-state and control decode.
   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      done      = 1'b0;
      start_acc = 1'b0;
      case (state_q)
         IDLE: begin
            busy = div_if.i_start;
            if (div_if.i_start) begin
               start_acc = 1'b1;
               state_d   = (div_if.i_rs == '0) ? DONE : ITER;
            end
         end
         ITER: begin
            busy = 1'b1;
            if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
         end
         FIX: begin
            busy    = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // One restoring step: trial subtract of the divisor from the shifted remainder.
   assign shifted = {rem_q, quo_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, div_q};
   assign q_fix   = qneg_q ? (~quo_q + WIDTH'(1)) : quo_q;
   assign r_fix   = rneg_q ? (~rem_q + WIDTH'(1)) : rem_q;

   // Datapath next-state.
   always_comb begin
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      quo_d  = quo_q;
      div_d  = div_q;
      res_d  = res_q;
      qneg_d = qneg_q;
      rneg_d = rneg_q;
      rsel_d = rsel_q;
      dbz_d  = dbz_q;
      if (start_acc) begin
         cnt_d  = '0;
         rem_d  = '0;
         quo_d  = mag(div_if.i_signed, div_if.i_rn);
         div_d  = mag(div_if.i_signed, div_if.i_rs);
         res_d  = '0;   // divide-by-zero skips FIX, so the result stays 0
         qneg_d = div_if.i_signed & (div_if.i_rn[WIDTH-1] ^ div_if.i_rs[WIDTH-1]);
         rneg_d = div_if.i_signed & div_if.i_rn[WIDTH-1];
         rsel_d = div_if.i_rem_sel;
         dbz_d  = (div_if.i_rs == '0);
      end else if (state_q == ITER) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
         end
      end else if (state_q == FIX) begin
         res_d = rsel_q ? r_fix : q_fix;
      end
   end

   // Datapath registers; reset clears everything, flush/stall freeze them.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         div_q  <= '0;
         res_q  <= '0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         rsel_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else if (upd) begin
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         div_q  <= div_d;
         res_q  <= res_d;
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
         rsel_q <= rsel_d;
         dbz_q  <= dbz_d;
      end
   end

   assign div_if.o_busy        = busy;
   assign div_if.o_done        = done;
   assign div_if.o_rd          = done ? res_q : '0;
   assign div_if.o_div_by_zero = done & dbz_q;

endmodule

// File: doc/zap_shifter_divide.md
Name: zap_shifter_divide

Overview:
- Iterative 32/32 integer divider sharing the shifter-stage slot with the multiply FSM; the inverse operation to the multiply unit.
- Radix-2 restoring algorithm, one quotient bit per clock. Supports signed and unsigned operands.
- Returns either the quotient or the remainder. Follows the same clear, stall and busy contract as the multiply unit so the ALU sequencer can treat both identically.

Parameters:
- WIDTH, 32, operand and result width; only 32 is supported.
- CNT_W, 5, iteration counter width, equal to $clog2(WIDTH).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_clear_from_writeback  in  1  pipeline flush from writeback; aborts the operation.
- i_data_stall  in  1  holds all state.
- i_clear_from_alu  in  1  pipeline flush from the ALU; aborts the operation.
- i_start  in  1  go signal; sampled only in IDLE.
- i_signed  in  1  1 selects SDIV semantics, 0 selects UDIV semantics.
- i_rem_sel  in  1  1 returns the remainder, 0 returns the quotient.
- i_rn  in  32  dividend.
- i_rs  in  32  divisor.
- o_rd  out  32  result; valid only while o_done is high, 0 otherwise.
- o_busy  out  1  unit busy; the pipeline must stall while this is high.
- o_done  out  1  result valid, high for exactly one cycle.
- o_div_by_zero  out  1  qualifies o_done; set when i_rs was 0.

Behaviour:
- Reset: synchronous, active-high. State goes to IDLE, and all datapath registers and the counter go to 0. Out of reset o_rd=0, o_busy=0, o_done=0, o_div_by_zero=0.
- Register update priority: i_reset, then i_clear_from_writeback (go to IDLE), then i_data_stall (hold everything), then i_clear_from_alu (go to IDLE), then normal update.
- FSM states: IDLE, ITER, FIX, DONE.
- IDLE:
  - o_busy = i_start, combinational.
  - On i_start, latch i_signed, i_rem_sel, |i_rs|, |i_rn|, quotient sign (sign(rn) XOR sign(rs), signed mode only) and remainder sign (sign(rn), signed mode only). Clear the partial remainder and the counter.
  - Next state is ITER, or DONE if i_rs == 0.
- Magnitude rule: for 0x80000000 in signed mode, the magnitude is the unsigned value 0x80000000. No overflow is possible.
- ITER:
  - o_busy=1.
  - Each cycle: shift {rem, quo} left by 1 to form 33-bit trial = rem_shifted - divisor.
  - If the trial is non-negative, rem = trial and the quotient LSB is 1. Otherwise the quotient LSB is 0.
  - Counter increments. After 32 iterations (counter wraps from 31) the next state is FIX.
- FIX:
  - o_busy=1.
  - Negate the quotient if its latched sign is set; negate the remainder if its latched sign is set.
  - Select the result by rem_sel. Next state is DONE.
- DONE:
  - o_busy=0, o_done=1, o_rd = result. Next state is IDLE.
  - i_start is ignored in DONE; a new operation needs a return to IDLE first.
- Divide by zero: result is 0 for both quotient and remainder (ARM semantics). o_div_by_zero=1 with o_done, at a latency of 1 cycle.
- Signed 0x80000000 / 0xFFFFFFFF: quotient is 0x80000000, remainder is 0 (wraps; no trap).
- Latency: start accepted at edge E0; ITER spans E1..E32; FIX at E33; o_done is high in the cycle after E33. Total busy is 34 cycles including the start cycle.
- Stall during any state freezes the counter, the operands and the state. o_busy and o_done stay as decoded from the held state.
- Clear in any state returns to IDLE next cycle; no o_done is produced for an aborted operation.
- Reset mid-operation behaves the same as a clear: IDLE next cycle, all registers 0.
- Clear and stall in the same cycle: i_clear_from_writeback wins over the stall, and the stall wins over i_clear_from_alu.

Test Plan:
- Unsigned 100/7, rem_sel=0 -> o_rd=14, o_done exactly 34 cycles after i_start, o_busy high for all 34 cycles before that. Repeat with rem_sel=1 -> o_rd=2.
- Signed -7/2 (0xFFFFFFF9 / 2) -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Signed 7/-2 -> quotient -3, remainder +1.
- Divide by zero: i_rn=0x12345678, i_rs=0, signed and unsigned -> o_done one cycle after start, o_rd=0, o_div_by_zero=1, no ITER cycles.
- Corner cases:
  - Signed 0x80000000/0xFFFFFFFF -> o_rd=0x80000000.
  - Unsigned 0xFFFFFFFF/1 -> 0xFFFFFFFF.
  - Unsigned 5/9 -> quotient 0, remainder 5.
- Stall: assert i_data_stall for 5 cycles mid-ITER on 1000/10 -> o_done delayed by exactly 5 cycles, o_rd=100.
- Abort: i_clear_from_alu at ITER cycle 10 -> IDLE next cycle, no o_done. Immediate new start 9/3 -> 3 after 34 cycles. Same check with i_clear_from_writeback asserted together with i_data_stall -> clear wins. Same check with i_reset -> all outputs 0.
